// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and helpers for the digit-serial add/subtract unit
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow from the latched operand MSBs (B uninverted) and the result MSB.
  function automatic logic calc_overflow(input logic ra, input logic rb,
                                         input logic rr, input logic op);
    if (op == OP_SUB) return (ra != rb) && (rr != ra);
    return (ra == rb) && (rr != ra);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple slice, time-multiplexed by the top level
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic [DIGIT-1:0] carry
);

  always_comb begin
    logic w_c;
    w_c   = cin;
    sum   = '0;
    carry = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c;
      w_c      = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
      carry[i] = w_c;
    end
  end

endmodule

// File: rtl/addsub_serial_unit.sv
// rtl/addsub_serial_unit.sv - digit-serial add/subtract with accumulate mode and registered flags
module addsub_serial_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("addsub_serial_unit: WIDTH must be a multiple of DIGIT");
  end

  state_t r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_sum_sh, r_carry_sh;
  logic [WIDTH-1:0] r_result, r_carry;
  logic             r_op, r_cin, r_a_msb, r_b_msb, r_ovf, r_zero;

  logic             w_accept, w_last;
  logic [DIGIT-1:0] w_sum, w_cvec;
  logic [WIDTH-1:0] w_sum_next, w_carry_next;

  assign ready    = (r_state == IDLE) || (r_state == DONE);
  assign busy     = (r_state == BUSY);
  assign done     = (r_state == DONE);
  assign w_accept = start && ready;
  assign w_last   = (r_cnt == CW'(NSLICE - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a     (r_a_sh[DIGIT-1:0]),
    .b     (r_b_sh[DIGIT-1:0]),
    .cin   (r_cin),
    .sum   (w_sum),
    .carry (w_cvec)
  );

  // Staging registers fill from the top so the final slice lands in the MSBs.
  assign w_sum_next   = (r_sum_sh   >> DIGIT) | (WIDTH'(w_sum)  << (WIDTH - DIGIT));
  assign w_carry_next = (r_carry_sh >> DIGIT) | (WIDTH'(w_cvec) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (w_last)   w_next = DONE;
      DONE:    w_next = w_accept ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry_sh <= '0;
      r_result   <= '0;
      r_carry    <= '0;
      r_op       <= OP_ADD;
      r_cin      <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a_sh  <= acc_en ? r_result : a;
      r_a_msb <= acc_en ? r_result[WIDTH-1] : a[WIDTH-1];
      r_b_sh  <= b ^ {WIDTH{op}};
      r_b_msb <= b[WIDTH-1];
      r_op    <= op;
      r_cin   <= op;
    end else if (r_state == BUSY) begin
      r_cnt      <= r_cnt + 1'b1;
      r_a_sh     <= r_a_sh >> DIGIT;
      r_b_sh     <= r_b_sh >> DIGIT;
      r_cin      <= w_cvec[DIGIT-1];
      r_sum_sh   <= w_sum_next;
      r_carry_sh <= w_carry_next;
      if (w_last) begin
        r_result <= w_sum_next;
        r_carry  <= w_carry_next ^ {r_op, {(WIDTH-1){1'b0}}};
        r_ovf    <= calc_overflow(r_a_msb, r_b_msb, w_sum_next[WIDTH-1], r_op);
        r_zero   <= ~|w_sum_next;
      end
    end
  end

  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

// File: doc/addsub_serial_unit.md
# addsub_serial_unit

Parametrised, digit-serial add/subtract unit for the calculator datapath. It is the multi-cycle successor of the fixed 6-bit plus/minus adder and adds:

- generic width;
- configurable bits-per-cycle;
- a start/done handshake;
- an accumulate mode that reuses the previous result as operand A;
- registered status flags: borrow, signed overflow, zero.

It sits between the operand registers and the display/result register.

## Interface
Parameters:
- WIDTH, 6, operand/result width in bits
- DIGIT, 2, bits processed per cycle; WIDTH mod DIGIT must be 0 (elaboration error otherwise)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled only when ready=1
- op  in  1  0 = add, 1 = subtract (A − B)
- acc_en  in  1  1 = use current result register as A instead of input a
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in BUSY
- done  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  sum/difference, held until next accepted start
- carry  out  WIDTH  per-bit carry vector; bit WIDTH-1 is carry-out for add, inverted (borrow) for subtract
- overflow  out  1  signed two's-complement overflow
- zero  out  1  result == 0

## Operation
- Subtract is A + ~B + 1, with the initial carry-in equal to op.
- States:
  - IDLE: ready=1. start=1 latches a (or result when acc_en=1), b, op; clears digit counter; → BUSY.
  - BUSY: each cycle adds one DIGIT-bit slice, LSB first. The slice carry-out is registered into the next slice. Sum and carry bits are written into shift/staging registers.
  - BUSY exits after WIDTH/DIGIT cycles → DONE. At that point result, carry, overflow and zero update together.
  - DONE: done=1 and ready=1 for one cycle; → IDLE. A start in DONE is accepted (→ BUSY) exactly as in IDLE.
- start in BUSY is ignored; latched operands are unaffected.
- Flags, with ra = latched A MSB, rb = latched B MSB, rr = result MSB:
  - carry[WIDTH-1] = raw_cout XOR op.
  - overflow: add → (ra==rb) && (rr!=ra); sub → (ra!=rb) && (rr!=ra).
  - zero = ~|result.
- Arithmetic is modulo 2^WIDTH; no saturation.
- acc_en=1 samples result as it is in the accept cycle, including a result produced in the same DONE cycle.
- After reset, acc_en=1 uses A = 0.

## Timing
- Reset (async assert, sync-safe release): state = IDLE, and result, carry, overflow, zero, done, busy = 0. ready = 1.
- Latency: start accepted at edge N → done high in cycle N + WIDTH/DIGIT + 1.
  - Example: WIDTH=6, DIGIT=2 gives 3 BUSY cycles, then DONE.
- Outputs change only on the edge entering DONE; they are stable in IDLE and BUSY.
- Back-to-back throughput: one operation per WIDTH/DIGIT + 1 cycles (start held high in DONE).
- Reset asserted mid-BUSY aborts immediately. No done is generated, and outputs go to reset values.
- DIGIT = WIDTH is legal: 1 BUSY cycle.

## Structure
- Package addsub_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - a function computing signed overflow from the three MSBs and op.
- One sub-module, digit_adder: DIGIT-bit combinational ripple slice. It takes a, b (already conditionally inverted) and cin, and returns sum[DIGIT-1:0] and carry[DIGIT-1:0]. It is instantiated once and time-multiplexed by the FSM.
- The top level holds the FSM, digit counter, operand shift registers and flag logic.

## Test plan
All scenarios use WIDTH=6, DIGIT=2.
- a=5, b=3, op=0 → done 4 cycles after start: result=8, carry[5]=0, overflow=0, zero=0.
- a=3, b=5, op=1 → result=6'h3E (−2), carry[5]=1 (borrow), overflow=0, zero=0.
- a=31, b=1, op=0 → result=32, overflow=1, carry[5]=0. Then a=32, b=1, op=1 → result=31, overflow=1.
- a=20, b=20, op=1 → result=0, zero=1, carry[5]=0. Then acc_en=1, b=10, op=0 started in the DONE cycle → result=10 with no idle gap.
- Sequence 5+3 (result 8), then acc_en=1, b=10, op=0 → result=18. A start pulse with a=63 mid-BUSY is ignored, so result stays 18.
- Start 5+3, deassert rst_n during the 2nd BUSY cycle → outputs immediately 0, no done pulse. After release, ready=1 and a fresh 1+1 yields 2.
